// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: slice width, controller states and slice-count helper.
package adder_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned nslice(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational ripple-carry slice; the only adder hardware in the serial datapath.
module nibble_adder
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);

  always_comb begin
    logic [SLICE_W:0] c;
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < SLICE_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[SLICE_W];
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a single nibble_adder,
// with valid/ready handshakes on operand and result sides.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NSLICE = nslice(WIDTH);
  localparam int unsigned CNT_W  = $clog2(NSLICE);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  nibble_adder u_nibble_adder (
    .a_i    (a_q[cnt_q*SLICE_W +: SLICE_W]),
    .b_i    (b_q[cnt_q*SLICE_W +: SLICE_W]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction as A + ~B + ~cin, so cout=1 means no borrow.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[cnt_q*SLICE_W +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        if (cnt_q == LastCnt) begin
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random operations against an
// arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the operand values, signed range test for overflow.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       input logic mcin, input logic msub,
                       output logic [WIDTH-1:0] es, output logic ec, output logic eo);
    int ua, ub, sa, sb, r, sr;
    ua = int'({16'h0, ma});
    ub = int'({16'h0, mb});
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!msub) begin
      r  = ua + ub + int'(mcin);
      sr = sa + sb + int'(mcin);
      ec = (r >= (1 << WIDTH));
    end else begin
      r  = ua - ub - int'(mcin);
      sr = sa - sb - int'(mcin);
      ec = (r >= 0);
    end
    es = r[WIDTH-1:0];
    eo = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic ocin, input logic osub, input int hold);
    logic [WIDTH-1:0] es;
    logic             ec, eo;
    int               cyc;
    model(oa, ob, ocin, osub, es, ec, eo);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = oa; b = ob; cin = ocin; sub = osub;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".busy_run"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, ".latency"}, 32'(cyc), 32'(NSLICE));
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".hold_result"}, {15'd0, cout, ovf, sum}, {15'd0, ec, eo, es});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".release_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".release_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".release_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.cout_ovf", {30'd0, cout, ovf}, 32'd0);

    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
    run_op("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    run_op("backpressure", 16'hABCD, 16'h1357, 1'b1, 1'b0, 5);
    run_op("sub_cin", 16'h1000, 16'h0FFF, 1'b1, 1'b1, 2);

    // Reset mid-operation, after two slices have been processed.
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.sum", 32'(sum), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst.no_result", 32'(seen), 32'd0);
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      run_op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencing controller that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple-carry slice over WIDTH/4 cycles. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It carries the inter-slice carry in a register and reports carry-out and signed overflow. It trades latency for area when wide adders are needed but only one nibble adder is budgeted.

## Interface
Parameters:
- WIDTH, 16, operand/result width; multiple of 4, minimum 8.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand set offered.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+cin, 1 = A−B−cin.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result.
- cout  out  1  final carry (sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- NSLICE = WIDTH/4. FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. Transfer on in_valid && in_ready captures a, b (or ~b if sub), and carry0 (cin if add, ~cin if sub). Goes to RUN with slice counter = 0.
- RUN: each cycle, the slice adds nibble[cnt] of the A register, nibble[cnt] of the B′ register, and the carry register.
  - The 4-bit sum is written into sum nibble[cnt]. The carry register takes the slice carry-out.
  - cnt increments. After cnt = NSLICE−1 is processed, go to DONE.
- Last slice: ovf = (a[MSB] == b′[MSB]) && (sum[MSB] != a[MSB]). cout = final carry register.
- DONE: out_valid=1. sum, cout and ovf are held stable until out_valid && out_ready, then return to IDLE.
- in_ready=0 in RUN and DONE. No accept is possible in the same cycle as a result handshake.
- Input ports are ignored outside the IDLE transfer cycle; changes during RUN have no effect.
- out_ready while out_valid=0 is ignored.
- The counter never wraps. It is cleared on every accept.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, counter=0, carry=0. In-flight operation is discarded with no result emitted.
- Reset has priority over every handshake in the same cycle.
- Latency: accept at edge E0. Slices process on edges E1..E_NSLICE. out_valid is high after E_NSLICE, which is NSLICE cycles after accept.
- Handshake in DONE at edge Ek: out_valid low and in_ready high after Ek. The next accept is possible at Ek+1.
- Peak throughput: one operation per NSLICE+2 cycles.
- All outputs are registered. in_ready, out_valid and busy decode from the state register only, with no combinational input-to-output path.

## Structure
- Package adder_pkg contains:
  - SLICE_W = 4.
  - The state typedef (IDLE, RUN, DONE).
  - Helper function for NSLICE.
- Sub-module nibble_adder: combinational 4-bit ripple-carry slice (a, b, cin → sum, cout), instantiated once.
- Counter width: $clog2(NSLICE). Operand registers: WIDTH each, indexed by counter.

## Test plan
All cases use WIDTH=16.
- Add 0x1234 + 0x0FFF, cin=0: sum=0x2233, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Add 0xFFFF + 0x0001, cin=0: sum=0x0000, cout=1, ovf=0. Add 0x7FFF + 0x0001: sum=0x8000, cout=0, ovf=1.
- Sub 0x0005 − 0x0007, cin=0: sum=0xFFFE, cout=0, ovf=0. Sub 0x8000 − 0x0001: sum=0x7FFF, cout=1, ovf=1.
- Backpressure: out_ready=0 for 5 cycles in DONE.
  - sum, cout and ovf stay stable; in_ready=0.
  - in_valid pulses during this window are not accepted.
  - The release handshake returns to IDLE.
- Operands changed during RUN: result still matches the values captured at accept.
- rst_n=0 for one cycle during RUN (cnt=2): out_valid never rises for that operation. in_ready=1 and busy=0 after the reset edge. A fresh 0x0001+0x0001 then yields 0x0002.
